// File: rtl/reg5_serializer.sv
// reg5_serializer: 5-bit parallel-to-serial converter with valid/ready handshakes on both sides.
// A new word is accepted in IDLE, or on the edge that consumes the last bit, so frames can run back to back.
module reg5_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in,
  input  logic       ld,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_first,
  output logic       ser_last,
  output logic       busy
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e     state_q, state_d;
  logic [4:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_bit;
  logic       in_shift;

  assign last_bit = (cnt_q == 3'd4);
  assign in_shift = (state_q == SHIFT);

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (ld) begin
          state_d = SHIFT;
          sh_d    = in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Accepting only when the last bit is consumed keeps back-to-back frames bubble-free.
        in_ready = last_bit && ser_ready;
        if (ser_ready) begin
          if (last_bit) begin
            if (ld) begin
              sh_d  = in;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
              sh_d    = '0;
              cnt_d   = '0;
            end
          end else begin
            sh_d  = LSB_FIRST ? {1'b0, sh_q[4:1]} : {sh_q[3:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_valid = in_shift;
  assign busy      = in_shift;
  assign ser_out   = in_shift && (LSB_FIRST ? sh_q[0] : sh_q[4]);
  assign ser_first = in_shift && (cnt_q == 3'd0);
  assign ser_last  = in_shift && last_bit;

endmodule

// File: tb/tb_reg5_serializer.sv
// Directed bench for reg5_serializer: one LSB-first and one MSB-first instance share all stimulus.
module tb_reg5_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] in_w = '0;
  logic       ld = 1'b0;
  logic       ser_ready = 1'b0;

  logic in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;
  logic in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, busy_m;

  // {in_ready, ser_valid, busy, ser_first, ser_last, ser_out}
  logic [5:0] st_l, st_m;
  assign st_l = {in_ready_l, ser_valid_l, busy_l, ser_first_l, ser_last_l, ser_out_l};
  assign st_m = {in_ready_m, ser_valid_m, busy_m, ser_first_m, ser_last_m, ser_out_m};

  int errs = 0;
  int checks = 0;

  reg5_serializer #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in(in_w), .ld(ld), .in_ready(in_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
    .ser_first(ser_first_l), .ser_last(ser_last_l), .busy(busy_l)
  );

  reg5_serializer #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in(in_w), .ld(ld), .in_ready(in_ready_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
    .ser_first(ser_first_m), .ser_last(ser_last_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    rst = 1'b1; ld = 1'b1; in_w = 5'b10101; ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (st_l !== 6'b100000) begin errs++; $display("FAIL reset_idle_l: got %b want %b", st_l, 6'b100000); end
    checks++;
    if (st_m !== 6'b100000) begin errs++; $display("FAIL reset_idle_m: got %b want %b", st_m, 6'b100000); end
    rst = 1'b0;
    @(posedge clk); #1;
    ld = 1'b0;
    checks++;
    if (st_l !== 6'b011101) begin errs++; $display("FAIL reset_first_accept_l: got %b want %b", st_l, 6'b011101); end
    checks++;
    if (st_m !== 6'b011101) begin errs++; $display("FAIL reset_first_accept_m: got %b want %b", st_m, 6'b011101); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL reset_frame_end: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
  endtask

  task automatic test_bit_order();
    logic exp_l [5];
    logic exp_m [5];
    exp_l = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_m = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    in_w = 5'b10110; ld = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (st_l !== {k == 4, 1'b1, 1'b1, k == 0, k == 4, exp_l[k]}) begin
        errs++; $display("FAIL order_lsb bit%0d: got %b want %b", k, st_l, {k == 4, 1'b1, 1'b1, k == 0, k == 4, exp_l[k]});
      end
      checks++;
      if (st_m !== {k == 4, 1'b1, 1'b1, k == 0, k == 4, exp_m[k]}) begin
        errs++; $display("FAIL order_msb bit%0d: got %b want %b", k, st_m, {k == 4, 1'b1, 1'b1, k == 0, k == 4, exp_m[k]});
      end
      @(posedge clk); #1;
    end
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL order_idle: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
  endtask

  task automatic test_stall();
    logic       rp [8];
    logic [4:0] rx_l, rx_m;
    int         n;
    rp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rx_l = '0; rx_m = '0; n = 0;
    in_w = 5'b01101; ld = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ser_ready = rp[c];
      #1;
      if (c >= 2 && c <= 4) begin
        checks++;
        if (st_l !== 6'b011001 || st_m !== 6'b011001) begin
          errs++; $display("FAIL stall_hold c%0d: got l=%b m=%b want %b", c, st_l, st_m, 6'b011001);
        end
      end
      if (ser_valid_l && ser_ready) begin
        if (n < 5) begin
          rx_l[n] = ser_out_l;
          rx_m[4 - n] = ser_out_m;
        end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 5) begin errs++; $display("FAIL stall_count: got %0d want 5", n); end
    checks++;
    if (rx_l !== 5'b01101 || rx_m !== 5'b01101) begin
      errs++; $display("FAIL stall_word: got l=%b m=%b want %b", rx_l, rx_m, 5'b01101);
    end
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL stall_idle: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq_l, seq_m;
    logic [4:0] exp_st;
    seq_l = '0; seq_m = '0;
    in_w = 5'h1F; ld = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    in_w = 5'h0A;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) ld = 1'b0;
      #1;
      exp_st = {(k == 4 || k == 9), 1'b1, 1'b1, (k == 0 || k == 5), (k == 4 || k == 9)};
      checks++;
      if (st_l[5:1] !== exp_st || st_m[5:1] !== exp_st) begin
        errs++; $display("FAIL b2b_status k%0d: got l=%b m=%b want %b", k, st_l[5:1], st_m[5:1], exp_st);
      end
      seq_l[k] = ser_out_l;
      seq_m[k] = ser_out_m;
      @(posedge clk); #1;
    end
    checks++;
    if (seq_l !== 10'b0101011111) begin errs++; $display("FAIL b2b_seq_l: got %b want %b", seq_l, 10'b0101011111); end
    checks++;
    if (seq_m !== 10'b0101011111) begin errs++; $display("FAIL b2b_seq_m: got %b want %b", seq_m, 10'b0101011111); end
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL b2b_idle: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
  endtask

  task automatic test_mid_reset();
    in_w = 5'b10110; ld = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (st_l !== 6'b011001 || st_m !== 6'b011001) begin
      errs++; $display("FAIL midrst_cnt2: got l=%b m=%b want %b", st_l, st_m, 6'b011001);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL midrst_async: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
        errs++; $display("FAIL midrst_aborted k%0d: got l=%b m=%b want %b", k, st_l, st_m, 6'b100000);
      end
    end
    in_w = 5'b00011; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    checks++;
    if (st_l !== 6'b011101) begin errs++; $display("FAIL midrst_next_l: got %b want %b", st_l, 6'b011101); end
    checks++;
    if (st_m !== 6'b011100) begin errs++; $display("FAIL midrst_next_m: got %b want %b", st_m, 6'b011100); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL midrst_idle: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
  endtask

  task automatic test_ignored_ld();
    logic [4:0] rx_l, rx_m;
    rx_l = '0; rx_m = '0;
    in_w = 5'b10110; ld = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        ld = 1'b1; in_w = 5'b01001;
      end else begin
        ld = 1'b0;
      end
      #1;
      if (k == 1) begin
        checks++;
        if (in_ready_l !== 1'b0 || in_ready_m !== 1'b0) begin
          errs++; $display("FAIL ignld_in_ready: got l=%b m=%b want 0", in_ready_l, in_ready_m);
        end
      end
      rx_l[k] = ser_out_l;
      rx_m[4 - k] = ser_out_m;
      @(posedge clk); #1;
    end
    checks++;
    if (rx_l !== 5'b10110 || rx_m !== 5'b10110) begin
      errs++; $display("FAIL ignld_word: got l=%b m=%b want %b", rx_l, rx_m, 5'b10110);
    end
    checks++;
    if (st_l !== 6'b100000 || st_m !== 6'b100000) begin
      errs++; $display("FAIL ignld_idle: got l=%b m=%b want %b", st_l, st_m, 6'b100000);
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_ignored_ld();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reg5_serializer.md
REG5_SERIALIZER -- requirements
Module: reg5_serializer

Interface
REQ-001 Parameter: LSB_FIRST, default 1, meaning: 1 sends bit 0 first; 0 sends bit 4 first.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in  input  5  parallel word to serialize.
REQ-006 Port: ld  input  1  word-offer valid; a word is accepted on an edge where ld && in_ready.
REQ-007 Port: in_ready  output  1  the block can accept a word this cycle.
REQ-008 Port: ser_out  output  1  current serial bit.
REQ-009 Port: ser_valid  output  1  ser_out holds a valid bit.
REQ-010 Port: ser_ready  input  1  downstream consumes the bit on an edge where ser_valid && ser_ready.
REQ-011 Port: ser_first  output  1  current bit is bit index 0 of the frame.
REQ-012 Port: ser_last  output  1  current bit is bit index 4 of the frame.
REQ-013 Port: busy  output  1  a frame is in progress (state SHIFT).

Function
REQ-014 State: IDLE or SHIFT; 5-bit shift register sh; 3-bit bit counter cnt (range 0..4); all registered.
REQ-015 IDLE: in_ready=1, ser_valid=0, busy=0; ser_out, ser_first and ser_last are all 0.
REQ-016 IDLE + ld at an edge: sh<=in, cnt<=0, go to SHIFT; the first bit appears in the cycle right after the accepting edge (1-cycle latency).
REQ-017 SHIFT: ser_valid=1, busy=1, ser_first=(cnt==0), ser_last=(cnt==4).
REQ-018 SHIFT with LSB_FIRST=1: ser_out=sh[0], and each consumed bit shifts sh right.
REQ-019 SHIFT with LSB_FIRST=0: ser_out=sh[4], and each consumed bit shifts sh left.
REQ-020 Edge with ser_valid && !ser_ready: sh and cnt hold, and ser_out is unchanged (stall of any length).
REQ-021 Edge with ser_ready and cnt<4: advance sh, cnt<=cnt+1.
REQ-022 in_ready in SHIFT = (cnt==4) && ser_ready; this is a combinational path from ser_ready and is permitted.
REQ-023 Edge with ser_ready, cnt==4, ld=1: sh<=in, cnt<=0, stay in SHIFT (back-to-back frames, no bubble).
REQ-024 Edge with ser_ready, cnt==4, ld=0: return to IDLE.
REQ-025 ld while in_ready=0 is ignored; in is not sampled and the current frame is unaffected.
REQ-026 Every accepted word produces exactly 5 consumed bits, in order; no bit is dropped or duplicated under any ser_ready pattern.
REQ-027 cnt never exceeds 4; no wrap beyond the frame.

Reset
REQ-028 rst=1 forces, asynchronously: state=IDLE, sh=0, cnt=0, ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0.
REQ-029 rst forces in_ready=1 (combinational from IDLE).
REQ-030 rst asserted mid-frame aborts the frame; the remaining bits are never emitted.
REQ-031 After rst deasserts, the first edge with ld=1 accepts a new word.
REQ-032 ld held high during rst has no effect until the first edge after rst is released.

Verification
REQ-033 Scenario 1: reset, in=5'b10110, ld pulse, ser_ready=1, LSB_FIRST=1 -> ser_out 0,1,1,0,1 on 5 consecutive cycles; ser_first on cycle 1; ser_last on cycle 5; then IDLE.
REQ-034 Scenario 2: LSB_FIRST=0, in=5'b10110, ser_ready=1 -> ser_out 1,0,1,1,0.
REQ-035 Scenario 3: ser_ready low for 3 cycles at cnt==2 -> ser_out and cnt hold for 3 cycles; the full 5-bit sequence still matches the word exactly.
REQ-036 Scenario 4: ld held high with words 5'h1F then 5'h0A, ser_ready=1 -> 10 contiguous valid bits with no bubble; in_ready high only in the last-bit cycle.
REQ-037 Scenario 5: rst pulsed at cnt==2 -> all outputs 0 and in_ready=1 immediately; the next word's output starts with ser_first=1.
REQ-038 Scenario 6: ld pulsed at cnt==1 with a different word -> the pulse is ignored and the original frame completes unchanged.
